// File: rtl/synth_mix_pkg.sv
// Shared types and width helpers for the stereo channel mixer.
package synth_mix_pkg;
  typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) ;
    return r;
  endfunction

  function automatic int pan_max(input int pan_w);
    return 1 << pan_w;
  endfunction

  // Headroom: full-scale sample * gain * weight summed over all voices, plus sign and margin.
  function automatic int acc_width(input int sample_w, input int gain_w,
                                   input int pan_w, input int num_ch);
    return sample_w + gain_w + pan_w + clog2(num_ch) + 2;
  endfunction
endpackage

// File: rtl/mix_sat.sv
// Scales an accumulated sum back to sample range, saturates and left-justifies it.
module mix_sat #(
  parameter int ACC_W    = 32,
  parameter int SAMPLE_W = 16,
  parameter int OUT_W    = 24,
  parameter int SHIFT    = 11
) (
  input  logic signed [ACC_W-1:0] sum,
  output logic        [OUT_W-1:0] result,
  output logic                    clip
);
  localparam logic signed [ACC_W-1:0] SMAX = {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SMIN = {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  logic signed [ACC_W-1:0] shifted;
  logic        [SAMPLE_W-1:0] sat;

  assign shifted = sum >>> SHIFT;

  always_comb begin
    clip = 1'b0;
    sat  = shifted[SAMPLE_W-1:0];
    if (shifted > SMAX) begin
      clip = 1'b1;
      sat  = SMAX[SAMPLE_W-1:0];
    end else if (shifted < SMIN) begin
      clip = 1'b1;
      sat  = SMIN[SAMPLE_W-1:0];
    end
  end

  assign result = OUT_W'(sat) << (OUT_W - SAMPLE_W);
endmodule

// File: rtl/stereo_channel_mixer.sv
// N-voice stereo mixer: snapshot a frame, accumulate one voice per clock, saturate L/R.
module stereo_channel_mixer
  import synth_mix_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int SAMPLE_W = 16,
  parameter int GAIN_W   = 8,
  parameter int PAN_W    = 4,
  parameter int OUT_W    = 24
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*SAMPLE_W-1:0] samples_in,
  input  logic                       in_ready,
  input  logic [NUM_CH*GAIN_W-1:0]   gain,
  input  logic [NUM_CH*PAN_W-1:0]    pan,
  input  logic [NUM_CH-1:0]          mute,
  input  logic                       mono,
  input  logic                       clear_flags,
  output logic [OUT_W-1:0]           out_l,
  output logic [OUT_W-1:0]           out_r,
  output logic                       out_ready,
  output logic                       busy,
  output logic                       clip_l,
  output logic                       clip_r,
  output logic                       dropped
);
  localparam int ACC_W   = acc_width(SAMPLE_W, GAIN_W, PAN_W, NUM_CH);
  localparam int IDX_W   = (NUM_CH > 1) ? clog2(NUM_CH) : 1;
  localparam int WW      = PAN_W + 1;
  localparam int PAN_MAX = pan_max(PAN_W);
  localparam int SHIFT   = GAIN_W - 1 + PAN_W;

  state_t                             state;
  logic [IDX_W-1:0]                   idx;
  logic [NUM_CH-1:0][SAMPLE_W-1:0]    s_q;
  logic [NUM_CH-1:0][GAIN_W-1:0]      g_q;
  logic [NUM_CH-1:0][PAN_W-1:0]       p_q;
  logic [NUM_CH-1:0]                  mute_q;
  logic                               mono_q;
  logic signed [ACC_W-1:0]            acc_l, acc_r;

  logic [WW-1:0]                      w_l, w_r;
  logic signed [ACC_W-1:0]            c_l, c_r, sg;
  logic [OUT_W-1:0]                   res_l, res_r;
  logic                               sat_l, sat_r;

  // Contribution of the voice currently selected by idx.
  always_comb begin
    w_l = WW'(PAN_MAX) - {1'b0, p_q[idx]};
    w_r = {1'b0, p_q[idx]};
    if (mono_q) begin
      w_l = WW'(PAN_MAX / 2);
      w_r = WW'(PAN_MAX / 2);
    end
    sg  = ACC_W'($signed(s_q[idx])) * $signed(ACC_W'(g_q[idx]));
    c_l = sg * $signed(ACC_W'(w_l));
    c_r = sg * $signed(ACC_W'(w_r));
    if (mute_q[idx]) begin
      c_l = '0;
      c_r = '0;
    end
  end

  mix_sat #(.ACC_W(ACC_W), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_l (
    .sum(acc_l), .result(res_l), .clip(sat_l));
  mix_sat #(.ACC_W(ACC_W), .SAMPLE_W(SAMPLE_W), .OUT_W(OUT_W), .SHIFT(SHIFT)) u_sat_r (
    .sum(acc_r), .result(res_r), .clip(sat_r));

  assign busy = (state != IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      idx       <= '0;
      s_q       <= '0;
      g_q       <= '0;
      p_q       <= '0;
      mute_q    <= '0;
      mono_q    <= 1'b0;
      acc_l     <= '0;
      acc_r     <= '0;
      out_l     <= '0;
      out_r     <= '0;
      out_ready <= 1'b0;
      clip_l    <= 1'b0;
      clip_r    <= 1'b0;
      dropped   <= 1'b0;
    end else begin
      out_ready <= 1'b0;
      // Sticky flags: a set on the same edge as clear_flags wins.
      if (clear_flags) begin
        clip_l  <= 1'b0;
        clip_r  <= 1'b0;
        dropped <= 1'b0;
      end
      if (in_ready && state != IDLE) dropped <= 1'b1;
      case (state)
        IDLE: if (in_ready) begin
          s_q    <= samples_in;
          g_q    <= gain;
          p_q    <= pan;
          mute_q <= mute;
          mono_q <= mono;
          acc_l  <= '0;
          acc_r  <= '0;
          idx    <= '0;
          state  <= ACCUM;
        end
        ACCUM: begin
          acc_l <= acc_l + c_l;
          acc_r <= acc_r + c_r;
          if (idx == IDX_W'(NUM_CH - 1)) state <= FINISH;
          else                           idx   <= idx + 1'b1;
        end
        FINISH: begin
          out_l     <= res_l;
          out_r     <= res_r;
          out_ready <= 1'b1;
          if (sat_l) clip_l <= 1'b1;
          if (sat_r) clip_r <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_stereo_channel_mixer.sv
// Directed bench for stereo_channel_mixer with hand-computed expectations.
module tb_stereo_channel_mixer;
  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] samples_in;
  logic        in_ready;
  logic [31:0] gain;
  logic [15:0] pan;
  logic [3:0]  mute;
  logic        mono;
  logic        clear_flags;
  logic [23:0] out_l, out_r;
  logic        out_ready, busy, clip_l, clip_r, dropped;

  int total = 0;
  int fails = 0;
  int lat;
  int cnt;

  stereo_channel_mixer dut (
    .clk(clk), .reset(reset), .samples_in(samples_in), .in_ready(in_ready),
    .gain(gain), .pan(pan), .mute(mute), .mono(mono), .clear_flags(clear_flags),
    .out_l(out_l), .out_r(out_r), .out_ready(out_ready), .busy(busy),
    .clip_l(clip_l), .clip_r(clip_r), .dropped(dropped));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic set_ch(input int k, input logic [15:0] s, input logic [7:0] g,
                        input logic [3:0] p, input logic m);
    samples_in[k*16 +: 16] = s;
    gain[k*8 +: 8]         = g;
    pan[k*4 +: 4]          = p;
    mute[k]                = m;
  endtask

  // One in_ready pulse; returns at the negedge after the sampling edge E0.
  task automatic fire();
    @(negedge clk); in_ready = 1'b1;
    @(negedge clk); in_ready = 1'b0;
  endtask

  // Counts rising edges until out_ready is seen; 99 means it never arrived.
  task automatic wait_out(output int n);
    n = 99;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_ready) begin n = c; break; end
    end
  endtask

  task automatic count_out(input int cycles, output int n);
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (out_ready) n++;
    end
  endtask

  initial begin
    reset = 1'b1; in_ready = 1'b0; samples_in = '0; gain = '0; pan = '0;
    mute = '0; mono = 1'b0; clear_flags = 1'b0;
    #1;
    chk("reset_out_l", 32'(out_l), 32'h0);
    chk("reset_flags", {26'b0, out_ready, busy, clip_l, clip_r, dropped, 1'b0}, 32'h0);
    #20; @(negedge clk); reset = 1'b0;

    // Hard left, single voice
    set_ch(0, 16'd1000, 8'h80, 4'd0, 1'b0);
    for (int k = 1; k < 4; k++) set_ch(k, 16'd0, 8'h80, 4'd0, 1'b1);
    fire();
    chk("busy_in_frame", 32'(busy), 32'h1);
    wait_out(lat);
    chk("latency", lat, 5);
    chk("left_only_l", 32'(out_l), 32'h03E800);
    chk("left_only_r", 32'(out_r), 32'h000000);
    chk("left_only_clip", {clip_l, clip_r}, 32'h0);
    @(posedge clk); #1;
    chk("out_ready_one_cycle", 32'(out_ready), 32'h0);
    chk("hold_l", 32'(out_l), 32'h03E800);

    // Centre pan
    set_ch(0, 16'd1000, 8'h80, 4'd8, 1'b0);
    fire(); wait_out(lat);
    chk("centre_l", 32'(out_l), 32'h01F400);
    chk("centre_r", 32'(out_r), 32'h01F400);

    // Mono overrides hard-left pan
    set_ch(0, 16'd1000, 8'h80, 4'd0, 1'b0); mono = 1'b1;
    fire(); mono = 1'b0; wait_out(lat);
    chk("mono_l", 32'(out_l), 32'h01F400);
    chk("mono_r", 32'(out_r), 32'h01F400);

    // Positive clip on the left
    for (int k = 0; k < 4; k++) set_ch(k, 16'd20000, 8'h80, 4'd0, 1'b0);
    fire(); wait_out(lat);
    chk("pos_sat_l", 32'(out_l), 32'h7FFF00);
    chk("pos_sat_r", 32'(out_r), 32'h000000);
    chk("pos_clip", {clip_l, clip_r}, 32'h2);

    // Negative clip
    for (int k = 0; k < 4; k++) set_ch(k, -16'sd20000, 8'h80, 4'd0, 1'b0);
    fire(); wait_out(lat);
    chk("neg_sat_l", 32'(out_l), 32'h800000);
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    chk("clear_clip", {clip_l, clip_r}, 32'h0);

    // Arithmetic shift floors toward -inf
    set_ch(0, 16'hFFFF, 8'h80, 4'd8, 1'b0);
    for (int k = 1; k < 4; k++) set_ch(k, 16'd0, 8'h80, 4'd0, 1'b1);
    fire(); wait_out(lat);
    chk("floor_l", 32'(out_l), 32'hFFFF00);
    chk("floor_r", 32'(out_r), 32'hFFFF00);

    // Overlapping in_ready is dropped; frame keeps E0 data
    set_ch(0, 16'd1000, 8'h80, 4'd0, 1'b0);
    fire();
    @(negedge clk); set_ch(0, 16'd300, 8'h80, 4'd15, 1'b0); in_ready = 1'b1;
    @(negedge clk); in_ready = 1'b0;
    wait_out(lat);
    chk("drop_latency", lat, 3);
    chk("drop_l", 32'(out_l), 32'h03E800);
    chk("drop_r", 32'(out_r), 32'h000000);
    chk("dropped_set", 32'(dropped), 32'h1);
    // Second request arrives while out_ready is high: must be accepted
    set_ch(0, 16'd1000, 8'h80, 4'd8, 1'b0); in_ready = 1'b1;
    @(posedge clk); #1; in_ready = 1'b0;
    wait_out(lat);
    chk("b2b_latency", lat, 5);
    chk("b2b_l", 32'(out_l), 32'h01F400);
    chk("b2b_r", 32'(out_r), 32'h01F400);
    // Clear and set on the same edge: set wins
    @(negedge clk); in_ready = 1'b1;
    @(negedge clk); in_ready = 1'b0;
    @(negedge clk); clear_flags = 1'b1; in_ready = 1'b1;
    @(negedge clk); clear_flags = 1'b0; in_ready = 1'b0;
    chk("set_beats_clear", 32'(dropped), 32'h1);
    wait_out(lat);
    @(negedge clk); clear_flags = 1'b1;
    @(negedge clk); clear_flags = 1'b0;
    chk("dropped_cleared", 32'(dropped), 32'h0);

    // Reset mid-frame clears outputs immediately and kills the frame
    set_ch(0, 16'd2000, 8'h80, 4'd0, 1'b0);
    fire();
    @(posedge clk); #2; reset = 1'b1; #1;
    chk("rst_async_l", 32'(out_l), 32'h0);
    chk("rst_async_r", 32'(out_r), 32'h0);
    chk("rst_async_busy", 32'(busy), 32'h0);
    @(negedge clk); reset = 1'b0;
    count_out(10, cnt);
    chk("no_out_after_rst", cnt, 0);
    fire(); wait_out(lat);
    chk("post_rst_latency", lat, 5);
    chk("post_rst_l", 32'(out_l), 32'h07D000);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule
